// File: rtl/directory_ctrl.sv
// directory_ctrl: 8-entry cache-coherence directory controller.
//
// Ports:
//   clock     single clock, all state updates on posedge
//   reset_n   asynchronous active-low reset
//   cdb_in    22-bit message from processors, 22'h3FFFFF when idle
//   dir_emit  22-bit registered directory message, 22'h3FFFFF when idle
//   busy      high while a transaction is outstanding
//   drop      one-cycle pulse when a request on cdb_in is ignored
//
// Message layout: [21:19] op, [18:16] node id, [15:0] payload.
// Outgoing INVALIDATE and FETCH carry the block tag in payload[15:13];
// FETCH payload[0] selects fetch-invalidate (1) or downgrade (0).
//
// Optional feature: define DIR_WB_TIMEOUT_EN to re-issue FETCH after
// WB_TIMEOUT cycles without a WRITEBACK.
//
// state    | meaning
// IDLE     | accept a request or an unsolicited WRITEBACK
// LOOKUP   | two cycles: register the directory entry, then decide
// SEND_INV | one INVALIDATE per cycle, ascending node id
// WAIT_WB  | FETCH issued, waiting for WRITEBACK from the owner
// REPLY    | DATA_REPLY on dir_emit, back to IDLE next edge
module directory_ctrl #(
  parameter int NUM_NODES  = 2,
  parameter int WB_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [21:0] cdb_in,
  output logic [21:0] dir_emit,
  output logic        busy,
  output logic        drop
);
  localparam logic [21:0] IDLE_MSG = 22'h3FFFFF;
  localparam logic [2:0]  OP_RM = 3'd0, OP_WB = 3'd3, OP_DR = 3'd4,
                          OP_INV = 3'd5, OP_FE = 3'd6;
  localparam logic [1:0]  ST_U = 2'd0, ST_S = 2'd1, ST_E = 2'd2;

  typedef enum logic [2:0] {IDLE, LOOKUP, SEND_INV, WAIT_WB, REPLY} state_t;
  state_t state, state_nxt;

  logic [1:0]           ent_st  [8];
  logic [NUM_NODES-1:0] ent_shr [8];
  logic [15:0]          ent_mem [8];

  logic [2:0]  in_op, in_node, in_tag;
  logic [15:0] in_data;
  logic        is_req;
  assign in_op   = cdb_in[21:19];
  assign in_node = cdb_in[18:16];
  assign in_tag  = cdb_in[15:13];
  assign in_data = cdb_in[15:0];
  assign is_req  = ~in_op[2];

  logic [2:0]           req_op, req_node, req_tag;
  logic                 lk_second;
  logic [1:0]           cur_st;
  logic [NUM_NODES-1:0] cur_shr;
  logic [15:0]          cur_mem;
  logic [NUM_NODES-1:0] pend, pend_nxt;
  logic [2:0]           owner, owner_nxt;
  logic                 fetch_inv, finv_nxt;
  logic [21:0]          emit_nxt;
  logic                 drop_nxt, capture;
  logic                 wr_en, wr_mem_en;
  logic [2:0]           wr_tag;
  logic [1:0]           wr_st;
  logic [NUM_NODES-1:0] wr_shr, req_mask, targets;
  logic [15:0]          wr_mem;

  function automatic logic [NUM_NODES-1:0] node_mask(input logic [2:0] id);
    node_mask = '0;
    for (int i = 0; i < NUM_NODES; i++) node_mask[i] = (3'(i) == id);
  endfunction

  function automatic logic [2:0] lowest(input logic [NUM_NODES-1:0] v);
    lowest = 3'd0;
    for (int i = NUM_NODES - 1; i >= 0; i--) if (v[i]) lowest = 3'(i);
  endfunction

`ifdef DIR_WB_TIMEOUT_EN
  logic [7:0] wb_cnt;
  logic       cnt_clr;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit_nxt  = IDLE_MSG;
    drop_nxt  = 1'b0;
    capture   = 1'b0;
    wr_en     = 1'b0;
    wr_mem_en = 1'b0;
    wr_tag    = req_tag;
    wr_st     = cur_st;
    wr_shr    = cur_shr;
    wr_mem    = in_data;
    pend_nxt  = pend;
    owner_nxt = owner;
    finv_nxt  = fetch_inv;
    req_mask  = node_mask(req_node);
    targets   = '0;
`ifdef DIR_WB_TIMEOUT_EN
    cnt_clr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_op == OP_WB) begin
          if (ent_st[in_tag] == ST_E && (ent_shr[in_tag] & node_mask(in_node)) != '0) begin
            wr_en     = 1'b1;
            wr_mem_en = 1'b1;
            wr_tag    = in_tag;
            wr_st     = ST_U;
            wr_shr    = '0;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (is_req) begin
          capture   = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        drop_nxt = is_req;
        if (lk_second) begin
          if (cur_st == ST_E && (cur_shr & req_mask) == '0) begin
            // Another node owns the block: pull it back first.
            owner_nxt = lowest(cur_shr);
            finv_nxt  = (req_op != OP_RM);
            emit_nxt  = {OP_FE, lowest(cur_shr), req_tag, 12'd0, req_op != OP_RM};
            state_nxt = WAIT_WB;
`ifdef DIR_WB_TIMEOUT_EN
            cnt_clr   = 1'b1;
`endif
          end else if (req_op == OP_RM) begin
            if (cur_st != ST_E) begin
              wr_en  = 1'b1;
              wr_st  = ST_S;
              wr_shr = cur_shr | req_mask;
            end
            emit_nxt  = {OP_DR, req_node, cur_mem};
            state_nxt = REPLY;
          end else begin
            // WRITE_MISS and UPGRADE both end with exclusive ownership.
            if (cur_st == ST_S) targets = cur_shr & ~req_mask;
            wr_en  = 1'b1;
            wr_st  = ST_E;
            wr_shr = req_mask;
            if (targets != '0) begin
              emit_nxt  = {OP_INV, lowest(targets), req_tag, 13'd0};
              pend_nxt  = targets & ~node_mask(lowest(targets));
              state_nxt = SEND_INV;
            end else begin
              emit_nxt  = {OP_DR, req_node, cur_mem};
              state_nxt = REPLY;
            end
          end
        end
      end
      SEND_INV: begin
        drop_nxt = is_req;
        if (pend != '0) begin
          emit_nxt = {OP_INV, lowest(pend), req_tag, 13'd0};
          pend_nxt = pend & ~node_mask(lowest(pend));
        end else begin
          emit_nxt  = {OP_DR, req_node, cur_mem};
          state_nxt = REPLY;
        end
      end
      WAIT_WB: begin
        if (in_op == OP_WB && in_node == owner) begin
          wr_en     = 1'b1;
          wr_mem_en = 1'b1;
          wr_st     = fetch_inv ? ST_E : ST_S;
          wr_shr    = fetch_inv ? req_mask : (req_mask | node_mask(owner));
          emit_nxt  = {OP_DR, req_node, in_data};
          state_nxt = REPLY;
        end else begin
          drop_nxt = is_req;
`ifdef DIR_WB_TIMEOUT_EN
          if (wb_cnt == 8'(WB_TIMEOUT - 1)) begin
            emit_nxt = {OP_FE, owner, req_tag, 12'd0, fetch_inv};
            cnt_clr  = 1'b1;
          end
`endif
        end
      end
      REPLY: begin
        drop_nxt  = is_req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        ent_st[i]  <= ST_U;
        ent_shr[i] <= '0;
        ent_mem[i] <= '0;
      end
      dir_emit  <= IDLE_MSG;
      drop      <= 1'b0;
      req_op    <= '0;
      req_node  <= '0;
      req_tag   <= '0;
      lk_second <= 1'b0;
      cur_st    <= ST_U;
      cur_shr   <= '0;
      cur_mem   <= '0;
      pend      <= '0;
      owner     <= '0;
      fetch_inv <= 1'b0;
    end else begin
      dir_emit  <= emit_nxt;
      drop      <= drop_nxt;
      pend      <= pend_nxt;
      owner     <= owner_nxt;
      fetch_inv <= finv_nxt;
      lk_second <= (state == LOOKUP) && !lk_second;
      if (capture) begin
        req_op   <= in_op;
        req_node <= in_node;
        req_tag  <= in_tag;
      end
      if (state == LOOKUP && !lk_second) begin
        cur_st  <= ent_st[req_tag];
        cur_shr <= ent_shr[req_tag];
        cur_mem <= ent_mem[req_tag];
      end
      if (wr_en) begin
        ent_st[wr_tag]  <= wr_st;
        ent_shr[wr_tag] <= wr_shr;
      end
      if (wr_mem_en) ent_mem[wr_tag] <= wr_mem;
    end
  end

`ifdef DIR_WB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              wb_cnt <= '0;
    else if (cnt_clr)          wb_cnt <= '0;
    else if (state == WAIT_WB) wb_cnt <= wb_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/directory_ctrl.md
DIRECTORY_CTRL -- requirements
Module: directory_ctrl

Interface
REQ-001 Parameter NUM_NODES, default 2, number of processor nodes, legal range 1..8.
REQ-002 Parameter WB_TIMEOUT, default 64, cycles to wait for WRITEBACK before re-issuing FETCH, legal range 2..255.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cdb_in  input  22  bus message from processors; 22'h3FFFFF is idle.
REQ-006 dir_emit  output  22  registered directory message; 22'h3FFFFF is idle.
REQ-007 busy  output  1  high while a transaction is outstanding.
REQ-008 drop  output  1  one-cycle pulse when a message on cdb_in is ignored.

Function
REQ-009 The message format SHALL be [21:19] op, [18:16] node id (source on cdb_in, destination on dir_emit), and [15:0] payload; request payload SHALL carry the block tag in [15:13] with all other payload bits zero.
REQ-010 Opcodes SHALL be 000 READ_MISS, 001 WRITE_MISS, 010 UPGRADE, 011 WRITEBACK (payload = data), 100 DATA_REPLY (payload = data), 101 INVALIDATE, 110 FETCH (payload[0]=1 fetch-invalidate, 0 downgrade), and 111 idle.
REQ-011 The block SHALL hold 8 entries; each entry SHALL contain a state (U=00, S=01, E=10), a NUM_NODES-bit sharer vector, and a 16-bit memory word.
REQ-012 FSM states SHALL be IDLE, LOOKUP, SEND_INV, WAIT_WB, and REPLY; busy SHALL be high in every state except IDLE.
REQ-013 In IDLE, a non-idle cdb_in with op 000..011 SHALL be latched (op, node, tag).
REQ-014 READ_MISS, WRITE_MISS, and UPGRADE SHALL move the FSM to LOOKUP; WRITEBACK SHALL be handled in IDLE per REQ-020.
REQ-015 The block SHALL ignore cdb_in ops 100..110 without asserting drop; requests arriving while busy SHALL be ignored and SHALL pulse drop.
REQ-016 READ_MISS to a U or S entry, or to an E entry owned by the requester: go to REPLY with mem[tag]; entry SHALL become S with the requester's sharer bit set, except that E owned by the requester SHALL stay unchanged.
REQ-017 READ_MISS to an E entry owned by o != n: emit FETCH(dest o, payload[0]=0), then WAIT_WB; on WRITEBACK from o, write mem[tag], set the entry to S with sharers {o,n}, then go to REPLY.
REQ-018 WRITE_MISS: U -> REPLY; S -> SEND_INV to each sharer != n, then REPLY; E owned by o != n -> FETCH(payload[0]=1), then WAIT_WB, write memory, then REPLY; the final entry state SHALL be E with sharers {n}.
REQ-019 UPGRADE from a node in the sharer vector SHALL behave as WRITE_MISS from S; UPGRADE from a node not in the sharer vector SHALL behave as WRITE_MISS.
REQ-020 WRITEBACK in IDLE from the owner of an E entry SHALL write mem[tag] and set the entry to U with sharers 0 in one cycle; any other WRITEBACK in IDLE SHALL pulse drop.
REQ-021 In WAIT_WB, messages other than WRITEBACK from the expected owner SHALL be ignored and SHALL pulse drop.
REQ-022 SEND_INV SHALL emit one INVALIDATE per cycle in ascending node id; a transaction with zero targets SHALL skip SEND_INV.
REQ-023 Latency: for a request sampled at edge N, the first emission SHALL be valid after edge N+2.
REQ-024 Each emission SHALL hold for exactly one cycle; REPLY SHALL follow the last INVALIDATE in the next cycle; the FSM SHALL return to IDLE on the edge after REPLY.
REQ-025 dir_emit SHALL be 22'h3FFFFF in every cycle with no emission.

Reset
REQ-026 Asserting reset_n low SHALL immediately force IDLE, dir_emit=22'h3FFFFF, busy=0, drop=0, all entries U with sharers 0, memory 16'h0000, and the timeout counter 0, even mid-transaction.

Configuration
REQ-027 With DIR_WB_TIMEOUT_EN defined, the counter SHALL clear on entry to WAIT_WB and increment each cycle; when it reaches WB_TIMEOUT, FETCH SHALL be re-emitted with identical fields and the counter SHALL clear.
REQ-028 Without DIR_WB_TIMEOUT_EN, the counter SHALL be absent and WAIT_WB SHALL wait indefinitely.

Verification
REQ-029 Reset, then READ_MISS node1 tag3 -> DATA_REPLY node1 payload 0x0000 two edges later, busy high 3 cycles, entry3=S{1}.
REQ-030 Node0 WRITE_MISS tag0, then node0 WRITEBACK 0x000A, then node1 READ_MISS tag0 -> DATA_REPLY node1 0x000A, entry0=U before the READ_MISS.
REQ-031 Node0 and node1 READ_MISS tag1, then node1 UPGRADE tag1 -> INVALIDATE node0, then DATA_REPLY node1 next cycle, entry1=E{1}.
REQ-032 Node0 owns tag2 E; node1 READ_MISS tag2 -> FETCH node0 payload0=0; node0 WRITEBACK 0x0008 -> DATA_REPLY node1 0x0008, entry2=S{0,1}.
REQ-033 Request during WAIT_WB -> drop pulse, no state change; with DIR_WB_TIMEOUT_EN, no WRITEBACK -> FETCH re-emitted after WB_TIMEOUT=64 cycles.
REQ-034 reset_n low during SEND_INV -> dir_emit idle and busy=0 immediately, all entries U.
